// File: rtl/sd_pkg.sv
// -----------------------------------------------------------------------------
// sd_pkg
// Shared definitions for the SD card SPI receive path: the receive state
// enumeration, the data-token byte values and the CRC16-CCITT byte update
// used to check data blocks.
// -----------------------------------------------------------------------------
package sd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HUNT,
    ST_DATA,
    ST_CRC_HI,
    ST_CRC_LO,
    ST_FINISH
  } rx_state_e;

  localparam logic [7:0]  SD_TOKEN_START = 8'hFE;
  localparam logic [7:0]  SD_IDLE_BYTE   = 8'hFF;
  localparam logic [15:0] CRC16_POLY     = 16'h1021;

  // Folds one byte into a CRC16-CCITT register, MSB first. The loop has a
  // fixed trip count, so it unrolls into eight XOR/shift stages.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc,
                                             input logic [7:0]  data_in);
    logic [15:0] c;
    c = crc ^ {data_in, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[15] ? ((c << 1) ^ CRC16_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/sd_block_ram.sv
// -----------------------------------------------------------------------------
// sd_block_ram
// 512 x 8 simple dual-port RAM holding one received data block.
// Ports:
//   clk      - clock
//   rst      - asynchronous active-high reset (read register only)
//   we       - write enable
//   wr_addr  - write address
//   wr_data  - write data
//   rd_addr  - read address
//   rd_data  - registered read data, one cycle after rd_addr
// A read and a write to the same address in one cycle returns the old data.
// -----------------------------------------------------------------------------
module sd_block_ram (
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [8:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [8:0] rd_addr,
  output logic [7:0] rd_data
);

  logic [7:0] mem [512];
  logic [7:0] rd_data_d;
  logic [7:0] rd_data_q;

  // Array contents are never reset so the memory maps onto a block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data_d = mem[rd_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= 8'h00;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/sd_block_rx.sv
// -----------------------------------------------------------------------------
// sd_block_rx
// Receive-side data stage of the SD SPI path. After start it polls the card
// one byte at a time for the start token, stores one data block in a RAM,
// checks the trailing CRC16 and exposes the block through a read port.
// Ports:
//   CLOCK_50    - system clock
//   reset       - asynchronous active-high reset
//   start       - one-cycle pulse, begin receiving one block (IDLE only)
//   byte_req    - one-cycle pulse, ask the shifter for one byte
//   rx_byte     - byte from the shifter
//   rx_valid    - rx_byte is valid this cycle
//   busy        - reception in progress
//   done        - one-cycle pulse when reception ends
//   crc_ok      - received CRC matched the computed CRC
//   timeout_err - no start token within TOKEN_TIMEOUT polled bytes
//   token_err   - card returned a data error token
//   rd_addr     - buffer read address
//   rd_data     - buffer read data, one cycle latency
// -----------------------------------------------------------------------------
module sd_block_rx
  import sd_pkg::*;
#(
  parameter int BLOCK_BYTES   = 512,
  parameter int TOKEN_TIMEOUT = 4096
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start,
  output logic       byte_req,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  output logic       busy,
  output logic       done,
  output logic       crc_ok,
  output logic       timeout_err,
  output logic       token_err,
  input  logic [8:0] rd_addr,
  output logic [7:0] rd_data
);

  localparam int POLL_W = $clog2(TOKEN_TIMEOUT + 1);

  rx_state_e         state_q, state_d;
  logic              outstanding_q, outstanding_d;
  logic [8:0]        count_q, count_d;
  logic [POLL_W-1:0] poll_q, poll_d;
  logic [15:0]       crc_q, crc_d;
  logic [7:0]        crc_hi_q, crc_hi_d;
  logic              crc_ok_q, crc_ok_d;
  logic              timeout_err_q, timeout_err_d;
  logic              token_err_q, token_err_d;

  logic              req_state;
  logic              consume;
  logic              err_token;
  logic              hunt_poll;
  logic              ram_we;

  // States in which the card is being clocked for bytes.
  assign req_state = (state_q == ST_HUNT)   || (state_q == ST_DATA) ||
                     (state_q == ST_CRC_HI) || (state_q == ST_CRC_LO);

  // A returned byte only counts if we actually asked for one.
  assign consume   = rx_valid && outstanding_q && req_state;

  // Data error token: upper nibble zero, value non-zero.
  assign err_token = (rx_byte[7:4] == 4'h0) && (rx_byte != 8'h00);

  // Idle fill and any other unrecognised byte are both polled over.
  assign hunt_poll = (rx_byte == SD_IDLE_BYTE) ||
                     !((rx_byte == SD_TOKEN_START) || err_token);

  // Next-state, byte flow control and datapath updates.
  always_comb begin
    state_d       = state_q;
    outstanding_d = outstanding_q;
    count_d       = count_q;
    poll_d        = poll_q;
    crc_d         = crc_q;
    crc_hi_d      = crc_hi_q;
    crc_ok_d      = crc_ok_q;
    timeout_err_d = timeout_err_q;
    token_err_d   = token_err_q;
    byte_req      = 1'b0;
    ram_we        = 1'b0;

    if (req_state && !outstanding_q) begin
      byte_req      = 1'b1;
      outstanding_d = 1'b1;
    end
    if (consume) begin
      outstanding_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          crc_ok_d      = 1'b0;
          timeout_err_d = 1'b0;
          token_err_d   = 1'b0;
          count_d       = '0;
          poll_d        = '0;
          crc_d         = 16'h0000;
          outstanding_d = 1'b0;
          state_d       = ST_HUNT;
        end
      end
      ST_HUNT: begin
        if (consume) begin
          if (rx_byte == SD_TOKEN_START) begin
            state_d = ST_DATA;
          end else if (err_token) begin
            token_err_d = 1'b1;
            state_d     = ST_FINISH;
          end else if (hunt_poll) begin
            poll_d = poll_q + 1'b1;
            if (poll_q == POLL_W'(TOKEN_TIMEOUT - 1)) begin
              timeout_err_d = 1'b1;
              state_d       = ST_FINISH;
            end
          end
        end
      end
      ST_DATA: begin
        if (consume) begin
          ram_we  = 1'b1;
          crc_d   = crc16_byte(crc_q, rx_byte);
          count_d = count_q + 1'b1;
          if (count_q == 9'(BLOCK_BYTES - 1)) begin
            state_d = ST_CRC_HI;
          end
        end
      end
      ST_CRC_HI: begin
        if (consume) begin
          crc_hi_d = rx_byte;
          state_d  = ST_CRC_LO;
        end
      end
      ST_CRC_LO: begin
        if (consume) begin
          crc_ok_d = ({crc_hi_q, rx_byte} == crc_q);
          state_d  = ST_FINISH;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      outstanding_q <= 1'b0;
      count_q       <= '0;
      poll_q        <= '0;
      crc_q         <= 16'h0000;
      crc_hi_q      <= 8'h00;
      crc_ok_q      <= 1'b0;
      timeout_err_q <= 1'b0;
      token_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      outstanding_q <= outstanding_d;
      count_q       <= count_d;
      poll_q        <= poll_d;
      crc_q         <= crc_d;
      crc_hi_q      <= crc_hi_d;
      crc_ok_q      <= crc_ok_d;
      timeout_err_q <= timeout_err_d;
      token_err_q   <= token_err_d;
    end
  end

  assign busy        = req_state;
  assign done        = (state_q == ST_FINISH);
  assign crc_ok      = crc_ok_q;
  assign timeout_err = timeout_err_q;
  assign token_err   = token_err_q;

  sd_block_ram u_ram (
    .clk     (CLOCK_50),
    .rst     (reset),
    .we      (ram_we),
    .wr_addr (count_q),
    .wr_data (rx_byte),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_sd_block_rx.sv
// -----------------------------------------------------------------------------
// tb_sd_block_rx
// Self-checking bench for sd_block_rx. A card model answers each byte_req
// from a byte queue after a random delay; a reference model scans the same
// queue to predict the outcome, the number of bytes consumed and the CRC.
// -----------------------------------------------------------------------------
module tb_sd_block_rx;

  localparam int BLOCK_BYTES   = 512;
  localparam int TOKEN_TIMEOUT = 4096;
  localparam int MAX_CYCLES    = 20000;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic [8:0] rd_addr;
  logic       byte_req;
  logic       busy;
  logic       done;
  logic       crc_ok;
  logic       timeout_err;
  logic       token_err;
  logic [7:0] rd_data;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] cardQ[$];
  logic [7:0] expBuf[BLOCK_BYTES];

  sd_block_rx #(
    .BLOCK_BYTES   (BLOCK_BYTES),
    .TOKEN_TIMEOUT (TOKEN_TIMEOUT)
  ) dut (
    .CLOCK_50    (clk),
    .reset       (reset),
    .start       (start),
    .byte_req    (byte_req),
    .rx_byte     (rx_byte),
    .rx_valid    (rx_valid),
    .busy        (busy),
    .done        (done),
    .crc_ok      (crc_ok),
    .timeout_err (timeout_err),
    .token_err   (token_err),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // CRC as the remainder of the augmented message divided by x^16+x^12+x^5+1.
  function automatic logic [15:0] modelCrc();
    logic [16:0] rem;
    logic [7:0]  cur;
    rem = '0;
    for (int j = 0; j < BLOCK_BYTES + 2; j++) begin
      cur = (j < BLOCK_BYTES) ? expBuf[j] : 8'h00;
      for (int b = 7; b >= 0; b--) begin
        rem = {rem[15:0], cur[b]};
        if (rem[16]) rem = rem ^ 17'h11021;
      end
    end
    return rem[15:0];
  endfunction

  // Scans the card queue with the hunting/data rules to predict the outcome.
  task automatic predict(output int consumed, output logic expT,
                         output logic expK, output logic expOk,
                         output bit isData);
    int          i;
    int          polls;
    logic [7:0]  b;
    logic [15:0] recv;
    i = 0; polls = 0;
    expT = 1'b0; expK = 1'b0; expOk = 1'b0; isData = 1'b0;
    while (i < cardQ.size()) begin
      b = cardQ[i];
      i++;
      if (b == 8'hFE) begin
        for (int j = 0; j < BLOCK_BYTES; j++) expBuf[j] = cardQ[i + j];
        i += BLOCK_BYTES;
        recv = {cardQ[i], cardQ[i + 1]};
        i += 2;
        expOk  = (recv == modelCrc());
        isData = 1'b1;
        break;
      end else if (b >= 8'h01 && b <= 8'h0F) begin
        expK = 1'b1;
        break;
      end else begin
        polls++;
        if (polls == TOKEN_TIMEOUT) begin
          expT = 1'b1;
          break;
        end
      end
    end
    consumed = i;
  endtask

  function automatic logic [7:0] noiseByte();
    logic [7:0] b;
    b = 8'($urandom_range(0, 255));
    if (b == 8'hFE || (b[7:4] == 4'h0 && b != 8'h00)) b = 8'hFF;
    return b;
  endfunction

  // Fills the queue with a random poll prefix, then a data block or an error.
  task automatic buildRandom(input bit allowErr);
    logic [15:0] crc;
    cardQ = {};
    repeat ($urandom_range(0, 6)) cardQ.push_back(noiseByte());
    if (allowErr && $urandom_range(0, 3) == 0) begin
      cardQ.push_back(8'($urandom_range(1, 15)));
      repeat (4) cardQ.push_back(8'hFF);
    end else begin
      cardQ.push_back(8'hFE);
      for (int j = 0; j < BLOCK_BYTES; j++) expBuf[j] = 8'($urandom_range(0, 255));
      crc = modelCrc();
      if ($urandom_range(0, 2) == 0) crc = crc ^ (16'h1 << $urandom_range(0, 15));
      for (int j = 0; j < BLOCK_BYTES; j++) cardQ.push_back(expBuf[j]);
      cardQ.push_back(crc[15:8]);
      cardQ.push_back(crc[7:0]);
    end
  endtask

  task automatic readCheck(input string tag, input int addr, input logic [7:0] exp);
    @(negedge clk);
    rd_addr = 9'(addr);
    @(negedge clk);
    checkOutput(tag, rd_data, exp);
  endtask

  // Starts one block, serves bytes from the card queue and checks the result.
  // With stopAfter >= 0 it returns right after that many bytes were served.
  task automatic applyStimulus(input string tag, input int pokeAt,
                               input int stopAfter, output bit isData);
    int   consumed, reqs, delivered, waitCnt, lastValid, doneCyc, extraReq;
    logic expT, expK, expOk;
    bit   gotDone, busyOk, poked;
    predict(consumed, expT, expK, expOk, isData);
    reqs = 0; delivered = 0; waitCnt = 0; lastValid = -10; doneCyc = -1;
    gotDone = 0; busyOk = 1; poked = 0;

    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput({tag, " start busy"}, busy, 1);
    checkOutput({tag, " start byte_req"}, byte_req, 1);

    for (int cyc = 0; cyc < MAX_CYCLES; cyc++) begin
      rx_valid = 1'b0;
      start    = 1'b0;
      if (done) begin
        gotDone = 1;
        doneCyc = cyc;
        break;
      end
      if (!busy) busyOk = 0;
      if (byte_req) reqs++;
      if (waitCnt > 0) begin
        waitCnt--;
        if (waitCnt == 0) begin
          rx_valid  = 1'b1;
          rx_byte   = (cardQ.size() > 0) ? cardQ.pop_front() : 8'hFF;
          delivered++;
          lastValid = cyc;
        end
      end
      if (byte_req) waitCnt = $urandom_range(1, 3);
      if (!poked && pokeAt >= 0 && delivered == pokeAt) begin
        start = 1'b1;
        poked = 1;
      end
      if (stopAfter >= 0 && delivered == stopAfter) begin
        @(negedge clk);
        rx_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end

    checkOutput({tag, " done seen"}, 32'(gotDone), 1);
    checkOutput({tag, " done latency"}, 32'(doneCyc - lastValid), 1);
    checkOutput({tag, " busy at done"}, busy, 0);
    checkOutput({tag, " busy while receiving"}, 32'(busyOk), 1);
    checkOutput({tag, " byte_req count"}, 32'(reqs), 32'(consumed));
    checkOutput({tag, " bytes consumed"}, 32'(delivered), 32'(consumed));
    checkOutput({tag, " crc_ok"}, crc_ok, expOk);
    checkOutput({tag, " timeout_err"}, timeout_err, expT);
    checkOutput({tag, " token_err"}, token_err, expK);

    @(negedge clk);
    checkOutput({tag, " done pulse width"}, done, 0);
    extraReq = 0;
    repeat (4) begin
      if (byte_req) extraReq++;
      @(negedge clk);
    end
    checkOutput({tag, " no byte_req after done"}, 32'(extraReq), 0);
    checkOutput({tag, " crc_ok holds"}, crc_ok, expOk);
  endtask

  initial begin
    bit          isData;
    logic [15:0] crc;
    int          a;

    reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00; rd_addr = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset byte_req", byte_req, 0);
    checkOutput("reset crc_ok", crc_ok, 0);
    checkOutput("reset timeout_err", timeout_err, 0);
    checkOutput("reset token_err", token_err, 0);
    checkOutput("reset rd_data", rd_data, 8'h00);
    reset = 1'b0;

    $display("[TB] all-0xFF block with known CRC 0x7FA1");
    cardQ = {};
    repeat (3) cardQ.push_back(8'hFF);
    cardQ.push_back(8'hFE);
    repeat (BLOCK_BYTES) cardQ.push_back(8'hFF);
    cardQ.push_back(8'h7F);
    cardQ.push_back(8'hA1);
    applyStimulus("allFF", -1, -1, isData);
    checkOutput("allFF crc_ok literal", crc_ok, 1);
    readCheck("allFF rd 0", 0, 8'hFF);
    readCheck("allFF rd 511", 511, 8'hFF);

    $display("[TB] incrementing block with corrupted CRC low byte");
    for (int j = 0; j < BLOCK_BYTES; j++) expBuf[j] = 8'(j);
    crc = modelCrc();
    cardQ = {};
    cardQ.push_back(8'hFE);
    for (int j = 0; j < BLOCK_BYTES; j++) cardQ.push_back(8'(j));
    cardQ.push_back(crc[15:8]);
    cardQ.push_back(crc[7:0] ^ 8'h01);
    applyStimulus("incr", -1, -1, isData);
    checkOutput("incr crc_ok literal", crc_ok, 0);
    readCheck("incr rd 300", 300, 8'h2C);
    readCheck("incr rd 511", 511, 8'hFF);

    $display("[TB] token timeout");
    cardQ = {};
    repeat (TOKEN_TIMEOUT) cardQ.push_back(8'hFF);
    applyStimulus("timeout", -1, -1, isData);
    checkOutput("timeout literal", timeout_err, 1);

    $display("[TB] data error token");
    cardQ = {};
    cardQ.push_back(8'hFF);
    cardQ.push_back(8'hFF);
    cardQ.push_back(8'h05);
    repeat (4) cardQ.push_back(8'hFF);
    applyStimulus("errtok", -1, -1, isData);
    checkOutput("errtok literal", token_err, 1);

    $display("[TB] reset in the middle of a block");
    cardQ = {};
    cardQ.push_back(8'hFE);
    repeat (BLOCK_BYTES + 2) cardQ.push_back(8'($urandom_range(0, 255)));
    applyStimulus("midreset", -1, 101, isData);
    #2 reset = 1'b1;
    #1;
    checkOutput("midreset busy", busy, 0);
    checkOutput("midreset done", done, 0);
    checkOutput("midreset byte_req", byte_req, 0);
    checkOutput("midreset crc_ok", crc_ok, 0);
    checkOutput("midreset timeout_err", timeout_err, 0);
    checkOutput("midreset token_err", token_err, 0);
    checkOutput("midreset rd_data", rd_data, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    cardQ = {};
    repeat (2) cardQ.push_back(8'hFF);
    cardQ.push_back(8'hFE);
    repeat (BLOCK_BYTES) cardQ.push_back(8'hFF);
    cardQ.push_back(8'h7F);
    cardQ.push_back(8'hA1);
    applyStimulus("after reset", -1, -1, isData);
    checkOutput("after reset crc_ok literal", crc_ok, 1);

    $display("[TB] spurious rx_valid in IDLE and start while busy");
    repeat (3) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_byte  = 8'hFE;
    end
    @(negedge clk);
    rx_valid = 1'b0;
    checkOutput("spurious busy", busy, 0);
    checkOutput("spurious byte_req", byte_req, 0);
    buildRandom(1'b0);
    applyStimulus("restart ignored", 200, -1, isData);
    readCheck("restart rd 150", 150, expBuf[150]);

    for (int n = 0; n < 3; n++) begin
      $display("[TB] random block %0d", n);
      buildRandom(1'b1);
      applyStimulus($sformatf("rand%0d", n), -1, -1, isData);
      if (isData) begin
        repeat (3) begin
          a = $urandom_range(0, BLOCK_BYTES - 1);
          readCheck($sformatf("rand%0d rd %0d", n, a), a, expBuf[a]);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sd_block_rx.md
# sd_block_rx

Receive-side data stage for the SD card SPI path. It sits directly downstream of the SPI byte shifter (`sd_interface`) and upstream of whatever consumes sector data (LED display, user logic). After a single-block read command has been accepted, it:
- polls the card byte by byte for the start token;
- captures one data block into an internal buffer;
- checks the trailing CRC16;
- exposes the buffer through a synchronous read port.

## Interface
Parameters:
- `BLOCK_BYTES`, 512: data bytes per block. Power of two, ≤ 512.
- `TOKEN_TIMEOUT`, 4096: maximum non-token bytes polled while hunting before a timeout is declared.

Ports:
- `CLOCK_50`  in  1  system clock; the only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins reception of one block.
- `byte_req`  out  1  one-cycle pulse asking the shifter to clock one byte (MOSI = 0xFF).
- `rx_byte`  in  8  byte returned by the shifter.
- `rx_valid`  in  1  one-cycle pulse; `rx_byte` is valid this cycle.
- `busy`  out  1  high from the `start` acceptance through the final cycle before `done`.
- `done`  out  1  one-cycle pulse when reception ends, on success or error.
- `crc_ok`  out  1  received CRC matched the computed CRC.
- `timeout_err`  out  1  start token not seen within `TOKEN_TIMEOUT` bytes.
- `token_err`  out  1  data error token received (byte with upper nibble 0x0 and value ≠ 0x00).
- `rd_addr`  in  9  buffer read address.
- `rd_data`  out  8  buffer data; registered, 1-cycle latency.

## Operation
- States:
  - IDLE
  - HUNT: on 0xFE → DATA.
  - DATA: after `BLOCK_BYTES` bytes → CRC_HI.
  - CRC_HI: → CRC_LO.
  - CRC_LO: → FINISH.
  - FINISH: for one cycle, pulses `done`, then → IDLE.
- IDLE:
  - `start` clears `crc_ok`, `timeout_err`, `token_err`, the byte counter and the CRC accumulator, then moves to HUNT.
  - `start` while not IDLE is ignored.
- Byte flow control:
  - Exactly one byte may be outstanding at a time.
  - In HUNT, DATA and CRC_* with no byte outstanding, assert `byte_req` for one cycle and set the outstanding flag.
  - `rx_valid` clears the flag and the byte is consumed.
  - `rx_valid` with no byte outstanding, or in IDLE/FINISH, is ignored.
- HUNT:
  - 0xFE → DATA.
  - 0xFF → increment the poll counter; on reaching `TOKEN_TIMEOUT`, set `timeout_err` → FINISH.
  - 0x01–0x0F → set `token_err`, latching nothing else → FINISH.
  - Any other value is treated as 0xFF.
- DATA:
  - Each byte is written to buffer[count] and folded into the CRC; count increments.
  - When count reaches `BLOCK_BYTES`, move to CRC_HI.
- CRC:
  - CRC16-CCITT, polynomial 0x1021, initial value 0x0000, MSB first, computed over data bytes only.
  - The CRC_HI byte is captured as the high byte of the received CRC, the CRC_LO byte as the low byte.
  - On entering FINISH, `crc_ok` = (received CRC == computed CRC).
- Buffer:
  - Contents stay valid after `done` until the next `start`.
  - `rd_addr` ≥ `BLOCK_BYTES` returns an undefined value.
  - Reads are permitted at any time; a read of a location being written in the same cycle returns old data.

## Timing
- Reset values:
  - state IDLE
  - `busy`, `done`, `byte_req`, `crc_ok`, `timeout_err`, `token_err` = 0
  - `rd_data` = 0x00
  - counters 0
  - outstanding flag 0
- Reset at any point returns to IDLE immediately. The buffer is not cleared, and its contents are undefined after a mid-block reset.
- `start` is accepted on cycle t. `busy` is high from t+1. The first `byte_req` is at t+1.
- After a `rx_valid` at cycle n, the next `byte_req` comes no earlier than n+1.
- The final byte (CRC_LO, or the terminating HUNT byte) arrives at cycle n:
  - n+1: FINISH; `busy` = 0, `done` = 1, status flags valid.
  - n+2: IDLE; `done` = 0.
- Status flags hold until the next accepted `start`.
- Error flags are mutually exclusive. `crc_ok` = 0 whenever an error flag is set.

## Structure
- Package `sd_pkg`:
  - state enum
  - constants `SD_TOKEN_START` = 8'hFE, `SD_IDLE_BYTE` = 8'hFF, `CRC16_POLY` = 16'h1021
  - function `crc16_byte(crc, byte)` implementing the 8-step unrolled update
- Sub-module `sd_block_ram`:
  - 512×8 simple dual-port RAM
  - one write port, one registered read port
  - inferred block RAM

## Test plan
- Block of 512×0xFF: token after 3 bytes of 0xFF, CRC bytes 0x7F, 0xA1 → `done` with `crc_ok` = 1; `rd_addr` 0 and 511 read 0xFF.
- Block of incrementing data (byte i = i[7:0]) with a correct CRC, but the final CRC byte XOR 0x01 → `crc_ok` = 0; `rd_addr` 300 returns 0x2C.
- 4096 bytes of 0xFF with no token → `timeout_err` = 1 at the 4096th byte; exactly 4096 `byte_req` pulses; `done` follows 1 cycle later.
- Byte 0x05 after 2×0xFF → `token_err` = 1, `done`; no further `byte_req` pulses.
- Reset asserted after 100 data bytes → all outputs 0 immediately. A following `start` plus a clean 0xFF block completes with `crc_ok` = 1.
- Spurious `rx_valid` in IDLE, and `start` while busy → no state change; the byte count of the in-progress block is unaffected.
